sprite_layer: RTL and testbench

- Parametrised sprite renderer for the VGA pipeline. It places one SPR_W x SPR_H indexed sprite at a programmable screen position, with integer scale, horizontal/vertical flip and a transparency key.
- Drives an external synchronous sprite ROM and a combinational palette, and produces registered RGB plus an opaque flag for layer compositing.
- Configuration is double-buffered so that updates take effect only at frame start.
- Counts opaque pixels per frame, for collision and coverage use.

---
 rtl/sprite_mem_if.sv | 42 ++++
 rtl/sprite_layer.sv | 171 +++++++++++++++++
 tb/tb_sprite_layer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_mem_if.sv
// sprite_mem_if: bundle between the sprite layer and its sprite ROM/palette.
//
//   rom_address  sprite -> ROM      registered texel address
//   rom_q        ROM    -> sprite   texel index, valid one cycle after rom_address
//   pal_index    sprite -> palette  mirror of rom_q
//   pal_red/green/blue  palette -> sprite, combinational from pal_index
//
// Handshake: there is no valid/ready pair. The link is a fixed-latency,
// free-running stream: the ROM always answers one cycle after an address
// is presented and the palette answers in the same cycle as pal_index.
// Neither side can stall the other.
interface sprite_mem_if #(
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 8
);
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_index;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;

  // Sprite layer side.
  modport master (
    output rom_address,
    output pal_index,
    input  rom_q,
    input  pal_red,
    input  pal_green,
    input  pal_blue
  );

  // ROM + palette side.
  modport slave (
    input  rom_address,
    input  pal_index,
    output rom_q,
    output pal_red,
    output pal_green,
    output pal_blue
  );
endinterface

// File: rtl/sprite_layer.sv
// sprite_layer: places one SPR_W x SPR_H indexed sprite on the VGA raster
// with integer scale (1/2/4/8), horizontal/vertical flip and a transparent
// palette index. Three-stage free-running pipeline:
//   E1  hit test + texel address -> rom_address
//   E2  external ROM registers rom_q
//   E3  palette colour / key test -> red, green, blue, opaque
// Configuration is written into a shadow copy and becomes active only on
// frame_start. Opaque pixels are counted per frame.
//
// Ports:
//   vga_clk, reset          pixel clock, async active-high reset
//   DrawX, DrawY, blank     raster position, 1 = active video
//   frame_start             pulse at first pixel of a frame
//   cfg_we, cfg_*           shadow configuration write
//   mem                     ROM / palette bundle (sprite_mem_if.master)
//   red, green, blue        registered pixel colour
//   opaque                  registered, 1 = sprite pixel shown
//   hit_count_last          opaque-pixel count of the previous frame
module sprite_layer #(
  parameter int SPR_W     = 32,
  parameter int SPR_H     = 32,
  parameter int ADDR_W    = 10,
  parameter int IDX_W     = 8,
  parameter int KEY_INDEX = 0,
  parameter int CNT_W     = 17
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              cfg_we,
  input  logic [9:0]        cfg_x,
  input  logic [9:0]        cfg_y,
  input  logic [1:0]        cfg_scale,
  input  logic              cfg_flip_h,
  input  logic              cfg_flip_v,
  input  logic              cfg_enable,
  sprite_mem_if.master      mem,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              opaque,
  output logic [CNT_W-1:0]  hit_count_last
);

  localparam int LX_W = $clog2(SPR_W);
  localparam int LY_W = $clog2(SPR_H);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] scale;
    logic       flip_h;
    logic       flip_v;
    logic       enable;
  } cfg_t;

  // Configuration
  cfg_t cfg_in;
  cfg_t sh_q, sh_d;
  cfg_t act_q, act_d;

  // Stage 1
  logic [10:0]       dx, dy;
  logic [13:0]       ext_w, ext_h;
  logic [LX_W-1:0]   lx;
  logic [LY_W-1:0]   ly;
  logic              hit_d;
  logic              hit1_q, blank1_q;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  // Stage 2
  logic              hit2_q, blank2_q;

  // Stage 3
  logic              vis;
  logic [3:0]        red_q, green_q, blue_q;
  logic [3:0]        red_d, green_d, blue_d;
  logic              opaque_q;

  // Counter
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, cnt_next;
  logic [CNT_W-1:0]  hit_last_q, hit_last_d;

  assign cfg_in = {cfg_x, cfg_y, cfg_scale, cfg_flip_h, cfg_flip_v, cfg_enable};

  // frame_start loads from sh_d so a coincident cfg_we writes straight through.
  always_comb begin
    sh_d  = cfg_we ? cfg_in : sh_q;
    act_d = frame_start ? sh_d : act_q;
  end

  // Stage 1: hit test and texel address. The extent is compared in 14 bits
  // (SPR_W << 3 needs more than 11), so overhang past the screen edge simply
  // never matches and is clipped.
  always_comb begin
    dx    = {1'b0, DrawX} - {1'b0, act_q.x};
    dy    = {1'b0, DrawY} - {1'b0, act_q.y};
    ext_w = 14'(SPR_W) << act_q.scale;
    ext_h = 14'(SPR_H) << act_q.scale;
    hit_d = act_q.enable & blank &
            (DrawX >= act_q.x) & (DrawY >= act_q.y) &
            ({3'b000, dx} < ext_w) & ({3'b000, dy} < ext_h);
    lx = LX_W'(dx >> act_q.scale);
    ly = LY_W'(dy >> act_q.scale);
    // Sprite dimensions are powers of two, so N-1-v is a bitwise invert.
    if (act_q.flip_h) lx = ~lx;
    if (act_q.flip_v) ly = ~ly;
    // Address holds on a miss so the ROM output stays quiet off-sprite.
    rom_addr_d = hit_d ? ADDR_W'({ly, lx}) : rom_addr_q;
  end

  // Stage 3: key test and colour select.
  always_comb begin
    vis     = hit2_q & blank2_q & (mem.rom_q != IDX_W'(KEY_INDEX));
    red_d   = vis ? mem.pal_red   : 4'd0;
    green_d = vis ? mem.pal_green : 4'd0;
    blue_d  = vis ? mem.pal_blue  : 4'd0;
  end

  // Counter: saturating increment; frame_start banks the total including
  // the pixel retiring in the same cycle.
  always_comb begin
    cnt_next   = (vis && (hit_cnt_q != {CNT_W{1'b1}})) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
    hit_cnt_d  = frame_start ? '0 : cnt_next;
    hit_last_d = frame_start ? cnt_next : hit_last_q;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sh_q       <= '0;
      act_q      <= '0;
      hit1_q     <= 1'b0;
      blank1_q   <= 1'b0;
      rom_addr_q <= '0;
      hit2_q     <= 1'b0;
      blank2_q   <= 1'b0;
      red_q      <= 4'd0;
      green_q    <= 4'd0;
      blue_q     <= 4'd0;
      opaque_q   <= 1'b0;
      hit_cnt_q  <= '0;
      hit_last_q <= '0;
    end else begin
      sh_q       <= sh_d;
      act_q      <= act_d;
      hit1_q     <= hit_d;
      blank1_q   <= blank;
      rom_addr_q <= rom_addr_d;
      hit2_q     <= hit1_q;
      blank2_q   <= blank1_q;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      opaque_q   <= vis;
      hit_cnt_q  <= hit_cnt_d;
      hit_last_q <= hit_last_d;
    end
  end

  assign mem.rom_address = rom_addr_q;
  assign mem.pal_index   = mem.rom_q;
  assign red             = red_q;
  assign green           = green_q;
  assign blue            = blue_q;
  assign opaque          = opaque_q;
  assign hit_count_last  = hit_last_q;

endmodule

// File: tb/tb_sprite_layer.sv
// tb_sprite_layer: self-checking bench for sprite_layer. A behavioural
// model (division-based texel lookup, shadow/active config copies, per-frame
// opaque count) produces the expected pixel for every driven cycle; a
// monitor pops and compares the pipeline output three cycles later.
module tb_sprite_layer;
  localparam int SPR_W  = 32;
  localparam int SPR_H  = 32;
  localparam int ADDR_W = 10;
  localparam int IDX_W  = 8;
  localparam int KEY    = 0;
  localparam int CNT_W  = 17;
  localparam int W      = 13;  // {opaque, r, g, b}

  typedef struct {
    int x;
    int y;
    int scale;
    bit fh;
    bit fv;
    bit en;
  } mcfg_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [9:0]       draw_x, draw_y;
  logic             blank, fs, we;
  logic [9:0]       cfg_x, cfg_y;
  logic [1:0]       cfg_scale;
  logic             cfg_flip_h, cfg_flip_v, cfg_enable;
  logic [3:0]       red, green, blue;
  logic             opaque;
  logic [CNT_W-1:0] hcl;

  sprite_mem_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) mem ();

  sprite_layer #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
    .KEY_INDEX(KEY), .CNT_W(CNT_W)
  ) dut (
    .vga_clk(clk), .reset(rst),
    .DrawX(draw_x), .DrawY(draw_y), .blank(blank), .frame_start(fs),
    .cfg_we(we), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_scale(cfg_scale),
    .cfg_flip_h(cfg_flip_h), .cfg_flip_v(cfg_flip_v), .cfg_enable(cfg_enable),
    .mem(mem),
    .red(red), .green(green), .blue(blue), .opaque(opaque),
    .hit_count_last(hcl)
  );

  // External synchronous ROM and combinational palette.
  logic [IDX_W-1:0] rom_mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) mem.rom_q <= rom_mem[mem.rom_address];
  assign mem.pal_red   = mem.pal_index[3:0];
  assign mem.pal_green = mem.pal_index[7:4];
  assign mem.pal_blue  = mem.pal_index[3:0] ^ mem.pal_index[7:4];

  // ---------------- model state / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int    n_cmp, n_err;
  bit    mon_en;
  mcfg_t m_sh, m_act, zero_cfg;
  int    m_count, m_last, m_addr;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Texel coordinates from screen coordinates by integer division.
  function automatic bit texel(int x, int y, bit b, mcfg_t c, output int addr);
    int m, dx, dy, tx, ty;
    addr = 0;
    if (!c.en || !b) return 0;
    m = 1 << c.scale;
    if (x < c.x || y < c.y) return 0;
    dx = x - c.x;
    dy = y - c.y;
    if (dx >= SPR_W * m || dy >= SPR_H * m) return 0;
    tx = dx / m;
    ty = dy / m;
    if (c.fh) tx = SPR_W - 1 - tx;
    if (c.fv) ty = SPR_H - 1 - ty;
    addr = ty * SPR_W + tx;
    return 1;
  endfunction

  function automatic logic [W-1:0] model_pixel(int x, int y, bit b, mcfg_t c);
    int a;
    logic [IDX_W-1:0] idx;
    if (!texel(x, y, b, c, a)) return '0;
    idx = rom_mem[a];
    if (idx == IDX_W'(KEY)) return '0;
    return {1'b1, idx[3:0], idx[7:4], idx[3:0] ^ idx[7:4]};
  endfunction

  // ---------------- driver tasks ----------------
  // One pixel per call; every cycle goes through here so the monitor's
  // fixed lag stays aligned.
  task automatic step(int x, int y, bit b, bit f, bit w, mcfg_t c);
    logic [W-1:0] e;
    int a;
    @(posedge clk);
    #1;
    // rom_address now reflects the previous pixel's stage-1 result.
    if (mon_en) check("rom_address", int'(mem.rom_address), m_addr);
    draw_x = 10'(x); draw_y = 10'(y); blank = b; fs = f; we = w;
    cfg_x = 10'(c.x); cfg_y = 10'(c.y); cfg_scale = 2'(c.scale);
    cfg_flip_h = c.fh; cfg_flip_v = c.fv; cfg_enable = c.en;
    e = model_pixel(x, y, b, m_act);
    exp_q.push_back(e);
    if (texel(x, y, b, m_act, a)) m_addr = a;
    if (e[W-1] && m_count < (1 << CNT_W) - 1) m_count++;
    if (w) m_sh = c;
    if (f) begin
      m_act   = m_sh;
      m_last  = m_count;
      m_count = 0;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, m_sh);
  endtask

  task automatic new_frame(bit w, mcfg_t c);
    idle(4);
    step(0, 0, 0, 1, w, c);
    idle(1);
    check("hit_count_last", int'(hcl), m_last);
  endtask

  task automatic write_cfg(mcfg_t c);
    step(0, 0, 0, 0, 1, c);
  endtask

  task automatic sweep(int x0, int x1, int y0, int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++)
        step(xx, yy, 1, 0, 0, m_sh);
  endtask

  task automatic pix_addr(int x, int y, int exp_addr);
    step(x, y, 1, 0, 0, m_sh);
    idle(1);
    check("directed_addr", int'(mem.rom_address), exp_addr);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && exp_q.size() >= 4) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if ({opaque, red, green, blue} !== e) begin
        n_err++;
        $display("FAIL pixel: got %h expected %h at %0t", {opaque, red, green, blue}, e, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    mcfg_t c;
    n_cmp = 0; n_err = 0; mon_en = 0;
    zero_cfg = '{0, 0, 0, 0, 0, 0};
    m_sh = zero_cfg; m_act = zero_cfg;
    m_count = 0; m_last = 0; m_addr = 0;
    for (int a = 0; a < (1 << ADDR_W); a++) rom_mem[a] = IDX_W'(a);
    rst = 1;
    draw_x = 0; draw_y = 0; blank = 0; fs = 0; we = 0;
    cfg_x = 0; cfg_y = 0; cfg_scale = 0; cfg_flip_h = 0; cfg_flip_v = 0; cfg_enable = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_opaque", int'(opaque), 0);
    check("reset_rgb", int'({red, green, blue}), 0);
    check("reset_rom_address", int'(mem.rom_address), 0);
    check("reset_hcl", int'(hcl), 0);
    rst = 0;
    mon_en = 1;

    // Layer disabled after reset: nothing shown, count stays 0.
    new_frame(0, m_sh);
    sweep(0, 63, 0, 7);
    new_frame(0, m_sh);
    check("disabled_hcl", int'(hcl), 0);

    // Unscaled sprite at (100,50), address-as-index ROM.
    c = '{100, 50, 0, 0, 0, 1};
    write_cfg(c);
    new_frame(0, c);
    pix_addr(100, 50, 0);
    pix_addr(131, 81, 1023);
    pix_addr(132, 81, 1023);
    sweep(96, 135, 48, 84);

    // 4x, horizontal flip at origin; cfg written with frame_start.
    c = '{0, 0, 2, 1, 0, 1};
    new_frame(1, c);
    for (int x = 0; x < 4; x++) pix_addr(x, 0, 31);
    pix_addr(127, 0, 0);
    pix_addr(128, 0, 0);
    sweep(0, 135, 0, 7);

    // Bottom-right overhang: 20x10 visible texels, keyed at addr 0 and 256.
    c = '{620, 470, 0, 0, 0, 1};
    new_frame(1, c);
    sweep(600, 639, 460, 479);
    new_frame(0, c);
    check("clip_count", int'(hcl), 198);

    // Mid-frame cfg write must not disturb the current frame.
    c = '{200, 100, 1, 0, 1, 1};
    new_frame(1, c);
    sweep(190, 340, 100, 104);
    c.x = 300;
    step(250, 105, 1, 0, 1, c);
    sweep(190, 340, 105, 110);
    new_frame(0, c);
    sweep(190, 380, 100, 106);
    c.x = 250;
    new_frame(1, c);
    sweep(190, 340, 100, 106);

    // Asynchronous reset in the middle of a visible row.
    c = '{100, 50, 0, 0, 0, 1};
    new_frame(1, c);
    for (int x = 100; x <= 115; x++) step(x, 60, 1, 0, 0, m_sh);
    check("pre_reset_opaque", int'(opaque), 1);
    #2;
    rst = 1;
    mon_en = 0;
    #1;
    check("async_opaque", int'(opaque), 0);
    check("async_rgb", int'({red, green, blue}), 0);
    check("async_rom_address", int'(mem.rom_address), 0);
    check("async_hcl", int'(hcl), 0);
    exp_q.delete();
    m_sh = zero_cfg; m_act = zero_cfg;
    m_count = 0; m_last = 0; m_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    mon_en = 1;
    new_frame(0, m_sh);
    sweep(96, 135, 48, 60);
    new_frame(0, m_sh);
    check("post_reset_hcl", int'(hcl), 0);

    // Randomised frames with random ROM content (about a quarter keyed).
    for (int f = 0; f < 6; f++) begin
      int ext, xlo, xhi, ylo, yhi;
      idle(4);
      for (int a = 0; a < (1 << ADDR_W); a++)
        rom_mem[a] = ($urandom_range(0, 3) == 0) ? '0 : IDX_W'($urandom);
      c.x = $urandom_range(0, 639);
      c.y = $urandom_range(0, 479);
      c.scale = $urandom_range(0, 3);
      c.fh = 1'($urandom_range(0, 1));
      c.fv = 1'($urandom_range(0, 1));
      c.en = ($urandom_range(0, 7) != 0);
      new_frame(1, c);
      ext = SPR_W << c.scale;
      xlo = (c.x > 10) ? c.x - 10 : 0;
      xhi = (c.x + ext + 10 < 639) ? c.x + ext + 10 : 639;
      ylo = (c.y > 10) ? c.y - 10 : 0;
      yhi = (c.y + ext + 10 < 479) ? c.y + ext + 10 : 479;
      for (int i = 0; i < 400; i++)
        step($urandom_range(xlo, xhi), $urandom_range(ylo, yhi),
             ($urandom_range(0, 9) != 0), 0, 0, m_sh);
    end
    new_frame(0, m_sh);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
